// File: rtl/counter_pkg.sv
// Shared types and constants for the dual up/down counter.
package counter_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_COUNT = 2'b00,
    MODE_SWAP  = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

endpackage

// File: rtl/reg_n.sv
// WIDTH-bit register with asynchronous active-low reset to a chosen value.
module reg_n #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture next value every edge; reset forces the configured value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dual_updown_counter.sv
// Paired up/down counters with count, swap, load and hold operations.
// Bound crossings either wrap (with a one-cycle Wrap pulse) or clamp.
module dual_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_load_up,
  input  logic [WIDTH-1:0]  i_load_down,
  output logic [WIDTH-1:0]  o_up_count,
  output logic [WIDTH-1:0]  o_down_count,
  output logic              o_up_terminal,
  output logic              o_down_terminal,
  output logic              o_up_wrap,
  output logic              o_down_wrap
);

  localparam logic [WIDTH:0]   L_STEP = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] L_MAX  = {WIDTH{1'b1}};
  localparam bit               L_SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] r_up;
  logic [WIDTH-1:0] r_dn;
  logic             r_up_wrap;
  logic             r_dn_wrap;

  logic [WIDTH-1:0] w_up_d;
  logic [WIDTH-1:0] w_dn_d;
  logic             w_up_wrap_d;
  logic             w_dn_wrap_d;
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH:0]   w_dn_diff;
  mode_e            w_mode;

  assign w_mode = mode_e'(i_mode);

  // Extra top bit holds the carry (up) or borrow (down) of the step.
  assign w_up_sum  = {1'b0, r_up} + L_STEP;
  assign w_dn_diff = {1'b0, r_dn} - L_STEP;

  reg_n #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0)
  ) u_up_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (w_up_d),
    .o_q     (r_up)
  );

  reg_n #(
    .WIDTH     (WIDTH),
    .RESET_VAL (L_MAX)
  ) u_dn_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (w_dn_d),
    .o_q     (r_dn)
  );

  // Next-state decode for both counters and their wrap flags.
  always_comb begin
    w_up_d      = r_up;
    w_dn_d      = r_dn;
    w_up_wrap_d = 1'b0;
    w_dn_wrap_d = 1'b0;
    if (i_enable) begin
      case (w_mode)
        MODE_COUNT: begin
          if (w_up_sum[WIDTH]) begin
            w_up_d      = L_SAT ? L_MAX : w_up_sum[WIDTH-1:0];
            w_up_wrap_d = !L_SAT;
          end else begin
            w_up_d = w_up_sum[WIDTH-1:0];
          end
          if (w_dn_diff[WIDTH]) begin
            w_dn_d      = L_SAT ? '0 : w_dn_diff[WIDTH-1:0];
            w_dn_wrap_d = !L_SAT;
          end else begin
            w_dn_d = w_dn_diff[WIDTH-1:0];
          end
        end
        MODE_SWAP: begin
          w_up_d = r_dn;
          w_dn_d = r_up;
        end
        MODE_LOAD: begin
          w_up_d = i_load_up;
          w_dn_d = i_load_down;
        end
        default: begin
          w_up_d = r_up;
          w_dn_d = r_dn;
        end
      endcase
    end
  end

  // Wrap pulses last exactly one cycle after the crossing edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_up_wrap <= 1'b0;
      r_dn_wrap <= 1'b0;
    end else begin
      r_up_wrap <= w_up_wrap_d;
      r_dn_wrap <= w_dn_wrap_d;
    end
  end

  assign o_up_count      = r_up;
  assign o_down_count    = r_dn;
  assign o_up_terminal   = (r_up == L_MAX);
  assign o_down_terminal = (r_dn == '0);
  assign o_up_wrap       = r_up_wrap;
  assign o_down_wrap     = r_dn_wrap;

endmodule

// File: tb/tb_dual_updown_counter.sv
// Scoreboard bench: three parameter variants share stimulus; a behavioural
// model pushes expected outputs at drive time, popped after each edge.
module tb_dual_updown_counter;

  typedef struct packed {
    logic [3:0] up;
    logic [3:0] dn;
    logic       uw;
    logic       dw;
    logic       ut;
    logic       dt;
  } exp_t;

  localparam int NI = 3;
  // Variant 0: defaults, 1: saturating, 2: step of three.
  localparam int STEPS [NI] = '{1, 1, 3};
  localparam bit SATS  [NI] = '{1'b0, 1'b1, 1'b0};

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] load_up;
  logic [3:0] load_dn;

  logic [3:0] up_o [NI];
  logic [3:0] dn_o [NI];
  logic       ut_o [NI];
  logic       dt_o [NI];
  logic       uw_o [NI];
  logic       dw_o [NI];

  logic [3:0] m_up [NI];
  logic [3:0] m_dn [NI];

  exp_t q_exp[$];
  int   n_vec;
  int   n_err;

  dual_updown_counter #(.WIDTH(4), .STEP(1), .SATURATE(0)) u_dut_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
    .i_load_up(load_up), .i_load_down(load_dn),
    .o_up_count(up_o[0]), .o_down_count(dn_o[0]),
    .o_up_terminal(ut_o[0]), .o_down_terminal(dt_o[0]),
    .o_up_wrap(uw_o[0]), .o_down_wrap(dw_o[0])
  );

  dual_updown_counter #(.WIDTH(4), .STEP(1), .SATURATE(1)) u_dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
    .i_load_up(load_up), .i_load_down(load_dn),
    .o_up_count(up_o[1]), .o_down_count(dn_o[1]),
    .o_up_terminal(ut_o[1]), .o_down_terminal(dt_o[1]),
    .o_up_wrap(uw_o[1]), .o_down_wrap(dw_o[1])
  );

  dual_updown_counter #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_dut_s3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
    .i_load_up(load_up), .i_load_down(load_dn),
    .o_up_count(up_o[2]), .o_down_count(dn_o[2]),
    .o_up_terminal(ut_o[2]), .o_down_terminal(dt_o[2]),
    .o_up_wrap(uw_o[2]), .o_down_wrap(dw_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_up[i] = 4'd0;
      m_dn[i] = 4'd15;
    end
  endtask

  // Outputs must match reset values right now (asynchronous reset).
  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("%s_u%0d_up", tag, i), 32'(up_o[i]), 32'd0);
      check_val($sformatf("%s_u%0d_dn", tag, i), 32'(dn_o[i]), 32'd15);
      check_val($sformatf("%s_u%0d_ut", tag, i), 32'(ut_o[i]), 32'd0);
      check_val($sformatf("%s_u%0d_dt", tag, i), 32'(dt_o[i]), 32'd0);
      check_val($sformatf("%s_u%0d_uw", tag, i), 32'(uw_o[i]), 32'd0);
      check_val($sformatf("%s_u%0d_dw", tag, i), 32'(dw_o[i]), 32'd0);
    end
  endtask

  // Apply inputs and push the model's expected post-edge outputs.
  task automatic set_and_push(input logic en, input logic [1:0] md,
                              input logic [3:0] lu, input logic [3:0] ld);
    enable  = en;
    mode    = md;
    load_up = lu;
    load_dn = ld;
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      int   nu;
      int   nd;
      nu = int'(m_up[i]) + STEPS[i];
      nd = int'(m_dn[i]) - STEPS[i];
      e.up = m_up[i];
      e.dn = m_dn[i];
      e.uw = 1'b0;
      e.dw = 1'b0;
      if (en) begin
        case (md)
          2'b00: begin
            if (nu > 15) begin
              e.up = SATS[i] ? 4'd15 : 4'(nu - 16);
              e.uw = !SATS[i];
            end else begin
              e.up = 4'(nu);
            end
            if (nd < 0) begin
              e.dn = SATS[i] ? 4'd0 : 4'(nd + 16);
              e.dw = !SATS[i];
            end else begin
              e.dn = 4'(nd);
            end
          end
          2'b01: begin
            e.up = m_dn[i];
            e.dn = m_up[i];
          end
          2'b10: begin
            e.up = lu;
            e.dn = ld;
          end
          default: ;
        endcase
      end
      e.ut = (e.up == 4'd15);
      e.dt = (e.dn == 4'd0);
      m_up[i] = e.up;
      m_dn[i] = e.dn;
      q_exp.push_back(e);
    end
  endtask

  task automatic edge_and_compare(input string tag);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      if (q_exp.size() == 0) begin
        check_val($sformatf("%s_u%0d_qempty", tag, i), 32'd1, 32'd0);
      end else begin
        e = q_exp.pop_front();
        check_val($sformatf("%s_u%0d_up", tag, i), 32'(up_o[i]), 32'(e.up));
        check_val($sformatf("%s_u%0d_dn", tag, i), 32'(dn_o[i]), 32'(e.dn));
        check_val($sformatf("%s_u%0d_uw", tag, i), 32'(uw_o[i]), 32'(e.uw));
        check_val($sformatf("%s_u%0d_dw", tag, i), 32'(dw_o[i]), 32'(e.dw));
        check_val($sformatf("%s_u%0d_ut", tag, i), 32'(ut_o[i]), 32'(e.ut));
        check_val($sformatf("%s_u%0d_dt", tag, i), 32'(dt_o[i]), 32'(e.dt));
      end
    end
  endtask

  task automatic drive(input string tag, input logic en, input logic [1:0] md,
                       input logic [3:0] lu, input logic [3:0] ld);
    set_and_push(en, md, lu, ld);
    edge_and_compare(tag);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    mode    = 2'b00;
    load_up = 4'd0;
    load_dn = 4'd0;
    model_reset();

    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Full count cycle from reset: both counters wrap on edge 16.
    for (int k = 1; k <= 16; k++) drive($sformatf("cnt%0d", k), 1'b1, 2'b00, 4'd0, 4'd0);

    // Enable low and HOLD mode both freeze and clear wrap pulses.
    drive("en_off", 1'b0, 2'b00, 4'd0, 4'd0);
    drive("hold", 1'b1, 2'b11, 4'd0, 4'd0);

    // Load, swap, count.
    drive("load39", 1'b1, 2'b10, 4'd3, 4'd9);
    drive("swap", 1'b1, 2'b01, 4'd0, 4'd0);
    drive("cnt_sw", 1'b1, 2'b00, 4'd0, 4'd0);

    // Clamp behaviour near the bounds.
    drive("load14_1", 1'b1, 2'b10, 4'd14, 4'd1);
    for (int k = 1; k <= 3; k++) drive($sformatf("satcnt%0d", k), 1'b1, 2'b00, 4'd0, 4'd0);

    // Step-of-three crossing on both counters at once.
    drive("load14_2", 1'b1, 2'b10, 4'd14, 4'd2);
    drive("s3cnt", 1'b1, 2'b00, 4'd0, 4'd0);

    // Arm a wrap, then reset between edges while a count is in flight.
    drive("load15_0", 1'b1, 2'b10, 4'd15, 4'd0);
    drive("wrapcnt", 1'b1, 2'b00, 4'd0, 4'd0);
    enable = 1'b1;
    mode   = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    #2;
    rst_n = 1'b1;
    model_reset();
    drive("postrst", 1'b1, 2'b00, 4'd0, 4'd0);

    // Random mix.
    for (int k = 0; k < 40; k++) begin
      drive($sformatf("rnd%0d", k), ($urandom_range(0, 7) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_updown_counter.md
DUAL_UPDOWN_COUNTER -- requirements
Module: dual_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the bit width of each counter (legal range 2..32).
REQ-002 The block SHALL have parameter STEP, default 1, setting the increment/decrement magnitude (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at bounds, 1 = clamp at bounds.
REQ-004 Clock  input  1  rising-edge clock; the only clock.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Enable  input  1  qualifies every state change; 0 = hold both counters.
REQ-007 Mode  input  2  operation: 00 COUNT, 01 SWAP, 10 LOAD, 11 HOLD.
REQ-008 LoadUp  input  WIDTH  value for the up counter in LOAD.
REQ-009 LoadDown  input  WIDTH  value for the down counter in LOAD.
REQ-010 UpCountS  output  WIDTH  up counter register.
REQ-011 DownCountS  output  WIDTH  down counter register.
REQ-012 UpTerminal  output  1  combinational, high when UpCountS == 2**WIDTH-1.
REQ-013 DownTerminal  output  1  combinational, high when DownCountS == 0.
REQ-014 UpWrap  output  1  registered one-cycle pulse: the up counter wrapped on the previous edge.
REQ-015 DownWrap  output  1  registered one-cycle pulse: the down counter wrapped on the previous edge.

Function
REQ-016 All registers SHALL update only on the rising edge of Clock, with the operation taken from the Enable/Mode/Load values sampled at that edge.
REQ-017 Enable=0 SHALL hold both counters regardless of Mode, and UpWrap/DownWrap SHALL be 0 on the following cycle.
REQ-018 COUNT SHALL set UpCountS <= UpCountS+STEP and DownCountS <= DownCountS-STEP in the same edge.
REQ-019 Arithmetic SHALL use a WIDTH+1-bit intermediate; the carry (up) or borrow (down) bit marks a bound crossing.
REQ-020 On a bound crossing with SATURATE=0, the counter SHALL keep the low WIDTH bits (modulo 2**WIDTH) and pulse its Wrap output high for exactly the next cycle.
REQ-021 With SATURATE=1, the up counter SHALL clamp to 2**WIDTH-1, the down counter SHALL clamp to 0, and Wrap outputs SHALL never assert.
REQ-022 SWAP SHALL exchange the two registers atomically (UpCountS <= old DownCountS, DownCountS <= old UpCountS), with no arithmetic and no Wrap pulse.
REQ-023 LOAD SHALL set UpCountS <= LoadUp and DownCountS <= LoadDown, with no Wrap pulse.
REQ-024 HOLD SHALL behave exactly as Enable=0.
REQ-025 Each Wrap output SHALL depend only on its own counter; both may pulse in the same cycle.
REQ-026 Back-to-back wrapping COUNT edges SHALL produce Wrap high on consecutive cycles, with no forced gap.

Reset
REQ-027 While Reset=0, the block SHALL immediately and asynchronously force UpCountS=0, DownCountS=2**WIDTH-1, UpWrap=0 and DownWrap=0.
REQ-028 Reset asserted mid-operation SHALL override any in-flight operation, and no Wrap pulse SHALL survive reset.
REQ-029 The first operation after Reset deasserts SHALL take effect on the first rising Clock edge at which Reset is high.

Structure
REQ-030 Package counter_pkg SHALL hold the mode enum type (MODE_COUNT, MODE_SWAP, MODE_LOAD, MODE_HOLD) and the 2-bit mode width constant.
REQ-031 The counters SHALL be built from one reusable sub-module, reg_n: a WIDTH-parametrised register with asynchronous active-low reset and a reset-value parameter, instantiated once per counter.
REQ-032 Next-state logic SHALL be a single combinational block with every output assigned on every path (no latches).
REQ-033 Non-default-mode behaviour SHALL be generated by parameters only, with no `define macros.

Verification (WIDTH=4, STEP=1, SATURATE=0 unless stated)
REQ-034 Reset low, then high -> Up=0, Down=15, UpTerminal=0, DownTerminal=0, both Wrap=0.
REQ-035 COUNT for 16 edges from reset -> Up steps 1..15 then 0, Down steps 14..0 then 15; UpWrap pulses once after edge 16 and DownWrap pulses once after edge 16.
REQ-036 LOAD Up=3/Down=9, then SWAP, then COUNT -> Up=9/Down=3, then Up=10/Down=2, with no Wrap pulse.
REQ-037 SATURATE=1, LOAD Up=14/Down=1, then COUNT x3 -> Up 15,15,15 and Down 0,0,0; Wrap never asserts; both Terminal flags held high.
REQ-038 STEP=3, LOAD Up=14/Down=2, then COUNT -> Up=1 and Down=15, with UpWrap and DownWrap high in the same cycle.
REQ-039 Reset pulsed low asynchronously between edges during COUNT with Enable=1 -> outputs return to reset values immediately, with no Wrap glitch afterwards.
